// File: rtl/mm_pkg.sv
// Shared matrix-multiplier definitions: DRAM widths, arbiter
// state encoding and requester slot numbers.
package mm_pkg;

  localparam int MM_ADDR_W = 16;
  localparam int MM_DATA_W = 8;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int REQ_PE0  = 0;
  localparam int REQ_PE1  = 1;
  localparam int REQ_WR   = 2;
  localparam int REQ_HOST = 3;

endpackage

// File: rtl/rr_priority_pick.sv
// One-hot pick of the first set request at or above ptr,
// wrapping around modulo N.
module rr_priority_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin DRAM port arbiter with accumulate lock, lock
// watchdog and a two-stage command/read-return tag pipeline.
module dram_port_arbiter
  import mm_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = MM_ADDR_W,
  parameter int DATA_W   = MM_DATA_W,
  parameter int LOCK_MAX = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ-1:0]    i_we,
  input  logic [NUM_REQ-1:0]    i_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
  output logic [NUM_REQ-1:0]    o_gnt,
  output logic [NUM_REQ-1:0]    o_rvalid,
  output logic [DATA_W-1:0]     o_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  output logic                  o_busy,
  output logic                  o_lock_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_t  state;
  logic [IW-1:0] rr;
  logic [IW-1:0] owner;
  logic [CW-1:0] lock_cnt;
  logic [IW-1:0] s1_id;
  logic          s2_valid;
  logic [IW-1:0] s2_id;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               acc;
  logic               force_rel;
  logic               sel_we;
  logic               sel_lock;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] k);
    return (int'(k) == NUM_REQ - 1) ? '0 : k + 1'b1;
  endfunction

  rr_priority_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req  (i_req),
    .ptr  (rr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .found(pick_found)
  );

  assign force_rel = (state == ARB_LOCKED) &&
                     (lock_cnt == CW'(LOCK_MAX));

  // No acceptance while reset is asserted: nothing may be lost.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    acc     = 1'b0;
    if (!i_rst) begin
      unique case (state)
        ARB_IDLE: begin
          gnt     = pick_gnt;
          gnt_idx = pick_idx;
          acc     = pick_found;
        end
        ARB_LOCKED: begin
          if (!force_rel && i_req[owner]) begin
            gnt[owner] = 1'b1;
            gnt_idx    = owner;
            acc        = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_gnt     = gnt;
  assign sel_we    = i_we[gnt_idx];
  assign sel_lock  = i_lock[gnt_idx];
  assign sel_addr  = i_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_wdata = i_wdata[gnt_idx*DATA_W +: DATA_W];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ARB_IDLE;
      rr          <= '0;
      owner       <= '0;
      lock_cnt    <= '0;
      o_lock_err  <= 1'b0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      s1_id       <= '0;
      s2_valid    <= 1'b0;
      s2_id       <= '0;
    end else begin
      o_lock_err <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (acc) begin
            if (sel_lock) begin
              owner    <= gnt_idx;
              state    <= ARB_LOCKED;
              lock_cnt <= CW'(1);
            end else begin
              rr <= nxt(gnt_idx);
            end
          end
        end
        ARB_LOCKED: begin
          if (force_rel) begin
            state      <= ARB_IDLE;
            rr         <= nxt(owner);
            lock_cnt   <= '0;
            o_lock_err <= 1'b1;
          end else if (acc && !sel_lock) begin
            state    <= ARB_IDLE;
            rr       <= nxt(owner);
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase

      o_mem_en <= acc;
      o_mem_we <= acc & sel_we;
      if (acc) begin
        o_mem_addr  <= sel_addr;
        o_mem_wdata <= sel_wdata;
        s1_id       <= gnt_idx;
      end
      s2_valid <= o_mem_en & ~o_mem_we;
      s2_id    <= s1_id;
    end
  end

  always_comb begin
    o_rvalid = '0;
    if (s2_valid) o_rvalid[s2_id] = 1'b1;
  end

  assign o_rdata = s2_valid ? i_mem_rdata : '0;
  assign o_busy  = (state == ARB_LOCKED) | o_mem_en |
                   s2_valid | (|i_req);

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter with a small
// 1-cycle-latency DRAM model.
module tb_dram_port_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [3:0]  lock;
  logic [63:0] addr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [7:0]  rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        lock_err;

  int n_checks;
  int n_errors;

  logic [7:0] mem [0:255];

  dram_port_arbiter #(
    .NUM_REQ(4), .ADDR_W(16), .DATA_W(8), .LOCK_MAX(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we),
    .i_lock(lock), .i_addr(addr), .i_wdata(wdata),
    .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_busy(busy),
    .o_lock_err(lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gnt, rvalid, rdata, mem_en, mem_we, busy, lock_err} !== '0) begin
      n_errors++;
      $display("FAIL reset_ctl: got gnt=%b rv=%b rd=%h en=%b we=%b busy=%b err=%b want all 0",
               gnt, rvalid, rdata, mem_en, mem_we, busy, lock_err);
    end
    n_checks++;
    if ({mem_addr, mem_wdata} !== '0) begin
      n_errors++;
      $display("FAIL reset_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_rr_reads();
    logic [3:0] eg [0:5];
    logic [3:0] erv [0:5];
    logic [7:0] erd [0:5];
    eg  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    erv = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    erd = '{8'h00, 8'h00, 8'h7C, 8'h2D, 8'hC2, 8'h49};
    step();
    req = 4'b1111; we = '0; lock = '0;
    for (int k = 0; k < 4; k++) addr[k*16 +: 16] = 16'h0024 + 16'(k);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (gnt !== eg[c]) begin
        n_errors++;
        $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt, eg[c]);
      end
      n_checks++;
      if (rvalid !== erv[c] || rdata !== erd[c]) begin
        n_errors++;
        $display("FAIL rr_rdata c%0d: got rv=%b rd=%h want rv=%b rd=%h",
                 c, rvalid, rdata, erv[c], erd[c]);
      end
      if (c == 1) begin
        n_checks++;
        if (!mem_en || mem_we || mem_addr !== 16'h0024) begin
          n_errors++;
          $display("FAIL rr_cmd: got en=%b we=%b addr=%h want 1 0 0024",
                   mem_en, mem_we, mem_addr);
        end
      end
      step();
      req = req & ~eg[c];
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rr_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    req = 4'b0100; we = 4'b0100;
    addr[32 +: 16] = 16'h0030; wdata[16 +: 8] = 8'hDC;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_errors++;
      $display("FAIL wr_gnt: got %b want 0100", gnt);
    end
    step();
    we = '0;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_errors++;
      $display("FAIL rd_gnt: got %b want 0100", gnt);
    end
    n_checks++;
    if (!mem_en || !mem_we || mem_addr !== 16'h0030 || mem_wdata !== 8'hDC) begin
      n_errors++;
      $display("FAIL wr_cmd: got en=%b we=%b a=%h d=%h want 1 1 0030 dc",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    step();
    req = '0;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 4'b0000 || !mem_en || mem_we) begin
      n_errors++;
      $display("FAIL wr_norv: got rv=%b en=%b we=%b want 0000 1 0",
               rvalid, mem_en, mem_we);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (rvalid !== 4'b0100 || rdata !== 8'hDC) begin
      n_errors++;
      $display("FAIL rd_after_wr: got rv=%b rd=%h want 0100 dc", rvalid, rdata);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (rvalid !== 4'b0000) begin
      n_errors++;
      $display("FAIL rd_single: got rv=%b want 0000", rvalid);
    end
    step();
  endtask

  task automatic test_lock();
    logic [3:0] eg [0:4];
    eg = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    idle_inputs();
    req = 4'b0001;
    step();
    req = 4'b0011; lock = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) lock = 4'b0000;
      @(negedge clk);
      n_checks++;
      if (gnt !== eg[c]) begin
        n_errors++;
        $display("FAIL lock_gnt c%0d: got %b want %b", c, gnt, eg[c]);
      end
      if (c == 2) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_errors++;
          $display("FAIL lock_busy: got %b want 1", busy);
        end
      end
      step();
      if (c == 3) req = 4'b0001;
      if (c == 4) req = 4'b0000;
    end
    step(); step();
  endtask

  task automatic test_lock_timeout();
    logic [3:0] g;
    int pulses;
    idle_inputs();
    pulses = 0;
    req = 4'b1001; lock = 4'b1000;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b1000) begin
      n_errors++;
      $display("FAIL to_lock_gnt: got %b want 1000", gnt);
    end
    step();
    req = 4'b0001; lock = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      g = (c == 9) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (gnt !== g) begin
        n_errors++;
        $display("FAIL to_gnt c%0d: got %b want %b", c, gnt, g);
      end
      n_checks++;
      if (lock_err !== (c == 9)) begin
        n_errors++;
        $display("FAIL to_err c%0d: got %b want %b", c, lock_err, (c == 9));
      end
      if (lock_err === 1'b1) pulses++;
      step();
      if (c == 9) req = '0;
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL to_pulses: got %0d want 1", pulses);
    end
    step(); step();
  endtask

  task automatic test_reset_midflight();
    idle_inputs();
    req = 4'b0010;
    addr[16 +: 16] = 16'h0025;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_errors++;
      $display("FAIL mid_gnt: got %b want 0010", gnt);
    end
    step();
    req = '0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gnt, rvalid, rdata, mem_en, mem_we, busy, lock_err} !== '0 ||
        {mem_addr, mem_wdata} !== '0) begin
      n_errors++;
      $display("FAIL mid_outs: got rv=%b rd=%h en=%b busy=%b addr=%h want 0",
               rvalid, rdata, mem_en, busy, mem_addr);
    end
    step();
    req = 4'b0110;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_errors++;
      $display("FAIL mid_rr0: got %b want 0010", gnt);
    end
    step();
    req = '0;
    step(); step(); step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    idle_inputs();
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      if (c < 5) addr[0 +: 16] = 16'h0040 + 16'(c);
      else req = '0;
      @(negedge clk);
      n_checks++;
      if (gnt !== ((c < 5) ? 4'b0001 : 4'b0000)) begin
        n_errors++;
        $display("FAIL b2b_gnt c%0d: got %b", c, gnt);
      end
      n_checks++;
      if (busy !== (c < 7)) begin
        n_errors++;
        $display("FAIL b2b_busy c%0d: got %b want %b", c, busy, (c < 7));
      end
      if (c >= 2 && c <= 6) begin
        exp_d = 8'h90 + 8'(c - 2);
        n_checks++;
        if (rvalid !== 4'b0001 || rdata !== exp_d) begin
          n_errors++;
          $display("FAIL b2b_data c%0d: got rv=%b rd=%h want 0001 %h",
                   c, rvalid, rdata, exp_d);
        end
      end
      step();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h24] = 8'h7C; mem[8'h25] = 8'h2D;
    mem[8'h26] = 8'hC2; mem[8'h27] = 8'h49;
    for (int i = 0; i < 5; i++) mem[8'h40 + i] = 8'h90 + 8'(i);
    mem_rdata = '0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_rr_reads();
    test_write_read();
    test_lock();
    test_lock_timeout();
    test_reset_midflight();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
